// File: rtl/cpu_pkg.sv
// Shared types and constants for the multi-cycle control sequencer.
package cpu_pkg;

  // FSM state encoding, also exported on state_o for debug
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_e;

  // Instruction class captured in DECODE
  typedef enum logic [1:0] {
    CLS_R     = 2'd0,
    CLS_I     = 2'd1,
    CLS_LOAD  = 2'd2,
    CLS_STORE = 2'd3
  } inst_class_e;

  // Supported major opcodes, inst[6:0]
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  // ALU operation select values
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_R   = 2'b10;
  localparam logic [1:0] ALU_I   = 2'b11;

endpackage

// File: rtl/cpu_op_decode.sv
// Combinational opcode classifier: opcode -> class, ALU select, legal flag.
module cpu_op_decode
  import cpu_pkg::*;
(
  input  logic [6:0]  opcode,
  output inst_class_e inst_class,
  output logic [1:0]  alu_op,
  output logic        legal
);

  // Map each supported opcode to its class; anything else is illegal
  always_comb begin
    inst_class = CLS_R;
    alu_op     = ALU_ADD;
    legal      = 1'b1;
    case (opcode)
      OP_R:     begin inst_class = CLS_R;     alu_op = ALU_R;   end
      OP_I:     begin inst_class = CLS_I;     alu_op = ALU_I;   end
      OP_LOAD:  begin inst_class = CLS_LOAD;  alu_op = ALU_ADD; end
      OP_STORE: begin inst_class = CLS_STORE; alu_op = ALU_ADD; end
      default:  legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB Moore FSM.
// Optional memory-wait watchdog enabled by defining CPU_SEQ_TMO_EN.
module cpu_seq_ctrl
  import cpu_pkg::*;
#(
  parameter int CNT_W = 32
`ifdef CPU_SEQ_TMO_EN
  , parameter int TMO_CYC = 16
`endif
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             halt_i,
  input  logic [6:0]       opcode_i,
  input  logic             mem_ready_i,
  output logic             pc_we_o,
  output logic             ir_we_o,
  output logic             reg_we_o,
  output logic [1:0]       alu_op_o,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic             busy_o,
  output logic             illegal_o,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] retired_o
);

  state_e           state_reg;
  inst_class_e      class_reg;
  logic [1:0]       alu_reg;
  logic             halt_reg;
  logic [CNT_W-1:0] retired_reg;

  inst_class_e dec_class;
  logic [1:0]  dec_alu;
  logic        dec_legal;
  logic        busy;
  logic        retire;
  logic        halt_pending;
  logic        tmo_hit;

  cpu_op_decode u_dec (
    .opcode     (opcode_i),
    .inst_class (dec_class),
    .alu_op     (dec_alu),
    .legal      (dec_legal)
  );

  assign busy         = (state_reg != ST_IDLE) && (state_reg != ST_TRAP);
  assign halt_pending = halt_reg | halt_i;
  assign retire       = (state_reg == ST_WB) ||
                        ((state_reg == ST_MEM) && (class_reg == CLS_STORE) && mem_ready_i);

`ifdef CPU_SEQ_TMO_EN
  localparam int TMO_W = $clog2(TMO_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt_reg;
  logic             mem_wait;

  assign mem_wait = ((state_reg == ST_FETCH) || (state_reg == ST_MEM)) && !mem_ready_i;
  assign tmo_hit  = mem_wait && (tmo_cnt_reg == TMO_W'(TMO_CYC - 1));

  // Count consecutive memory-wait cycles; any ready or state change restarts it
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmo_cnt_reg <= '0;
    end else if (mem_wait && !tmo_hit) begin
      tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
    end else begin
      tmo_cnt_reg <= '0;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // State sequencing, class capture, halt latch and retirement counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg   <= ST_IDLE;
      class_reg   <= CLS_R;
      alu_reg     <= ALU_ADD;
      halt_reg    <= 1'b0;
      retired_reg <= '0;
    end else begin
      if (busy) begin
        halt_reg <= halt_reg | halt_i;
      end
      // A retiring instruction either stops (clearing the latch) or
      // continues with no halt pending, so the latch ends up clear.
      if (retire) begin
        retired_reg <= retired_reg + CNT_W'(1);
        halt_reg    <= 1'b0;
      end
      case (state_reg)
        ST_IDLE: begin
          if (start_i) begin
            state_reg <= ST_FETCH;
            halt_reg  <= halt_i;
          end
        end
        ST_FETCH: begin
          if (mem_ready_i)  state_reg <= ST_DECODE;
          else if (tmo_hit) state_reg <= ST_TRAP;
        end
        ST_DECODE: begin
          if (dec_legal) begin
            class_reg <= dec_class;
            alu_reg   <= dec_alu;
            state_reg <= ST_EXEC;
          end else begin
            state_reg <= ST_TRAP;
          end
        end
        ST_EXEC: begin
          if ((class_reg == CLS_LOAD) || (class_reg == CLS_STORE)) state_reg <= ST_MEM;
          else                                                     state_reg <= ST_WB;
        end
        ST_MEM: begin
          if (mem_ready_i) begin
            if (class_reg == CLS_STORE) state_reg <= halt_pending ? ST_IDLE : ST_FETCH;
            else                        state_reg <= ST_WB;
          end else if (tmo_hit) begin
            state_reg <= ST_TRAP;
          end
        end
        ST_WB: begin
          state_reg <= halt_pending ? ST_IDLE : ST_FETCH;
        end
        default: begin
          state_reg <= ST_TRAP;
        end
      endcase
    end
  end

  // Moore decode of the enables; only ir_we and the store pc_we see mem_ready
  always_comb begin
    pc_we_o   = 1'b0;
    ir_we_o   = 1'b0;
    reg_we_o  = 1'b0;
    alu_op_o  = ALU_ADD;
    mem_req_o = 1'b0;
    mem_we_o  = 1'b0;
    case (state_reg)
      ST_FETCH: begin
        mem_req_o = 1'b1;
        ir_we_o   = mem_ready_i;
      end
      ST_EXEC: begin
        alu_op_o = alu_reg;
      end
      ST_MEM: begin
        mem_req_o = 1'b1;
        mem_we_o  = (class_reg == CLS_STORE);
        pc_we_o   = (class_reg == CLS_STORE) && mem_ready_i;
      end
      ST_WB: begin
        reg_we_o = 1'b1;
        pc_we_o  = 1'b1;
        alu_op_o = alu_reg;
      end
      default: ;
    endcase
  end

  assign busy_o    = busy;
  assign illegal_o = (state_reg == ST_TRAP);
  assign state_o   = state_reg;
  assign retired_o = retired_reg;

endmodule
